// File: rtl/boton_ar.sv
// Push-button debouncer: produces a stable level plus one-cycle rise/fall pulses.
// Define BOTON_AR_SYNC_EN to insert a two-flop synchronizer in front of the filter.
module boton_ar #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_in,
  output logic boton_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s;
  logic            out_q, out_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

`ifdef BOTON_AR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], boton_in};
    end
  end

  assign s = sync_q[1];
`else
  assign s = boton_in;
`endif

  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      // Qualified change: commit the new level and flag the matching edge.
      out_d  = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign boton_out  = out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_boton_ar.sv
// Self-checking bench for boton_ar (DEBOUNCE_CYCLES=5, synchronizer disabled).
module tb_boton_ar;

  localparam int unsigned N = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic boton_in = 1'b0;
  logic boton_out, rise_pulse, fall_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Reference: the output flips once the most recent N samples since the last
  // flip/reset all disagree with it.
  bit out_m = 1'b0;
  bit rise_m = 1'b0;
  bit fall_m = 1'b0;
  bit hist[$];

  boton_ar #(.DEBOUNCE_CYCLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .boton_in  (boton_in),
    .boton_out (boton_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit b);
    bit all_diff;
    rise_m = 1'b0;
    fall_m = 1'b0;
    if (r) begin
      out_m = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(b);
      if (hist.size() > N) void'(hist.pop_front());
      all_diff = (hist.size() == N);
      foreach (hist[i]) if (hist[i] == out_m) all_diff = 1'b0;
      if (all_diff) begin
        out_m  = ~out_m;
        rise_m = out_m;
        fall_m = ~out_m;
        hist.delete();
      end
    end
  endtask

  // Apply one clock of stimulus, then compare all outputs against the model.
  task automatic step(input bit r, input bit b, input string tag);
    reset    = r;
    boton_in = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    chk({tag, ".out"}, boton_out, out_m);
    chk({tag, ".rise"}, rise_pulse, rise_m);
    chk({tag, ".fall"}, fall_pulse, fall_m);
    vectors++;
    assert (!(rise_pulse && fall_pulse))
    else begin
      miscompares++;
      $error("FAIL %s.both at %0t: observed rise=%b fall=%b expected not both", tag, $time,
             rise_pulse, fall_pulse);
    end
  endtask

  initial begin
    bit  lvl;
    int  len;
    bit  bounce[5];

    #2;
    // Reset then idle
    step(1'b1, 1'b0, "reset");
    step(1'b1, 1'b0, "reset");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle");

    // Clean press, with absolute timing checks independent of the model
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, "press");
      chk("press.abs_out", boton_out, logic'(i >= 5));
      chk("press.abs_rise", rise_pulse, logic'(i == 5));
    end

    // Release
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, "release");
      chk("release.abs_out", boton_out, logic'(i < 5));
      chk("release.abs_fall", fall_pulse, logic'(i == 5));
    end

    // Bounce rejection
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    foreach (bounce[i]) begin
      step(1'b0, bounce[i], "bounce");
      chk("bounce.abs_out", boton_out, 1'b0);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, "bounce_hold");
      chk("bounce.abs_out2", boton_out, logic'(i >= 5));
      chk("bounce.abs_rise", rise_pulse, logic'(i == 5));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "release2");

    // Reset mid-count with input still high
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "midcount");
    step(1'b1, 1'b1, "midreset");
    chk("midreset.abs_out", boton_out, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b1, "after_reset");
      chk("after_reset.abs_out", boton_out, logic'(i >= 5));
    end

    // Randomized runs of varying length, occasional reset
    lvl = 1'b0;
    for (int k = 0; k < 120; k++) begin
      lvl = ~lvl;
      len = int'($urandom_range(1, 8));
      for (int j = 0; j < len; j++) begin
        step(($urandom_range(0, 49) == 0), lvl, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
